// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit drain.
package uart_pkg;

  // FSM encodings; these values are visible on diag_state.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_START = 3'd3,
    ST_DATA  = 3'd4,
    ST_STOP  = 3'd5
  } uart_state_t;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_drain_baud_counter.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
module baud_counter #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count_reg;

  // Free-running modulo counter; clear holds it at phase 0 so a new state starts a full period.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_reg <= '0;
    end else if (count_reg == TERMINAL) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign tick = (count_reg == TERMINAL);

endmodule

// File: rtl/uart_tx_drain.sv
// Pops bytes from an upstream FIFO and serialises them LSB first as UART frames.
module uart_tx_drain
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1,
  parameter int RD_LATENCY   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       empty,
  input  logic [7:0] rdata,
  output logic       read,
  output logic       tx,
  output logic       busy,
  output logic [2:0] diag_state,
  output logic [2:0] diag_bitcnt
);

  // Reject unsupported configurations at elaboration.
  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $fatal(1, "uart_tx_drain: CLKS_PER_BIT must be >= 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $fatal(1, "uart_tx_drain: STOP_BITS must be 1 or 2");
  end
  if (RD_LATENCY != 0 && RD_LATENCY != 1) begin : g_bad_rd_latency
    $fatal(1, "uart_tx_drain: RD_LATENCY must be 0 or 1");
  end

  localparam logic [2:0] LAST_BIT  = 3'(UART_DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  uart_state_t state_reg;
  logic        read_reg;
  logic        tx_reg;
  logic [7:0]  shift_reg;
  logic [2:0]  bitcnt_reg;
  logic        stop_cnt_reg;
  logic        baud_clear;
  logic        baud_tick;

  // The divider idles at phase 0 outside the timed states, so START always begins on a fresh period.
  // START->DATA, bit->bit and STOP exits all happen on the terminal count, where the divider wraps to 0 anyway.
  assign baud_clear = (state_reg == ST_IDLE) || (state_reg == ST_FETCH) || (state_reg == ST_WAIT);

  baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(baud_clear),
    .tick (baud_tick)
  );

  // Frame sequencer: fetch one byte, then drive start, 8 data bits and stop bits with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      read_reg     <= 1'b0;
      tx_reg       <= UART_IDLE_LEVEL;
      shift_reg    <= '0;
      bitcnt_reg   <= '0;
      stop_cnt_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          tx_reg       <= UART_IDLE_LEVEL;
          stop_cnt_reg <= 1'b0;
          if (!empty) begin
            state_reg <= ST_FETCH;
            read_reg  <= 1'b1;
          end
        end
        ST_FETCH: begin
          read_reg <= 1'b0;
          if (RD_LATENCY == 0) begin
            shift_reg <= rdata;
            tx_reg    <= 1'b0;
            state_reg <= ST_START;
          end else begin
            state_reg <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          shift_reg <= rdata;
          tx_reg    <= 1'b0;
          state_reg <= ST_START;
        end
        ST_START: begin
          if (baud_tick) begin
            state_reg  <= ST_DATA;
            bitcnt_reg <= '0;
            tx_reg     <= shift_reg[0];
          end
        end
        ST_DATA: begin
          if (baud_tick) begin
            if (bitcnt_reg == LAST_BIT) begin
              state_reg  <= ST_STOP;
              bitcnt_reg <= '0;
              tx_reg     <= UART_IDLE_LEVEL;
            end else begin
              shift_reg  <= shift_reg >> 1;
              bitcnt_reg <= bitcnt_reg + 3'd1;
              tx_reg     <= shift_reg[1];
            end
          end
        end
        ST_STOP: begin
          if (baud_tick) begin
            if (stop_cnt_reg == LAST_STOP) begin
              state_reg <= ST_IDLE;
            end else begin
              stop_cnt_reg <= stop_cnt_reg + 1'b1;
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          read_reg  <= 1'b0;
          tx_reg    <= UART_IDLE_LEVEL;
        end
      endcase
    end
  end

  assign read        = read_reg;
  assign tx          = tx_reg;
  assign busy        = (state_reg != ST_IDLE);
  assign diag_state  = state_reg;
  assign diag_bitcnt = bitcnt_reg;

endmodule

// File: tb/tb_uart_tx_drain.sv
// Directed bench for uart_tx_drain: three instances (show-ahead, registered FIFO, two stop bits).
module tb_uart_tx_drain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Per-instance signals: 0 = default, 1 = RD_LATENCY=1, 2 = STOP_BITS=2
  logic       rst0, rst1, rst2;
  logic       empty0, empty1, empty2;
  logic [7:0] rdata0, rdata1, rdata2;
  logic       read0, read1, read2;
  logic       tx0, tx1, tx2;
  logic       busy0, busy1, busy2;
  logic [2:0] st0, st1, st2;
  logic [2:0] bc0, bc1, bc2;

  uart_tx_drain u0 (
    .clk(clk), .rst(rst0), .empty(empty0), .rdata(rdata0), .read(read0),
    .tx(tx0), .busy(busy0), .diag_state(st0), .diag_bitcnt(bc0)
  );
  uart_tx_drain #(.RD_LATENCY(1)) u1 (
    .clk(clk), .rst(rst1), .empty(empty1), .rdata(rdata1), .read(read1),
    .tx(tx1), .busy(busy1), .diag_state(st1), .diag_bitcnt(bc1)
  );
  uart_tx_drain #(.STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst2), .empty(empty2), .rdata(rdata2), .read(read2),
    .tx(tx2), .busy(busy2), .diag_state(st2), .diag_bitcnt(bc2)
  );

  // Small FIFO models feeding each instance
  logic [7:0] mem0 [0:15];
  logic [7:0] mem1 [0:15];
  logic [7:0] mem2 [0:15];
  logic [3:0] wp0 = 4'd0, rp0 = 4'd0;
  logic [3:0] wp1 = 4'd0, rp1 = 4'd0;
  logic [3:0] wp2 = 4'd0, rp2 = 4'd0;

  assign empty0 = (wp0 == rp0);
  assign empty1 = (wp1 == rp1);
  assign empty2 = (wp2 == rp2);
  assign rdata0 = mem0[rp0];
  assign rdata2 = mem2[rp2];

  always @(posedge clk) begin
    if (read0 && (wp0 != rp0)) rp0 <= rp0 + 4'd1;
    if (read2 && (wp2 != rp2)) rp2 <= rp2 + 4'd1;
    if (read1 && (wp1 != rp1)) begin
      rdata1 <= mem1[rp1];
      rp1    <= rp1 + 4'd1;
    end
  end

  // Event counters sampled on the active edge
  int reads0 = 0, reads1 = 0, reads2 = 0, waits1 = 0, stops2 = 0;
  always @(posedge clk) begin
    reads0 <= reads0 + (read0 ? 1 : 0);
    reads1 <= reads1 + (read1 ? 1 : 0);
    reads2 <= reads2 + (read2 ? 1 : 0);
    waits1 <= waits1 + ((st1 == 3'd2) ? 1 : 0);
    stops2 <= stops2 + ((st2 == 3'd5) ? 1 : 0);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int sel, input logic [7:0] d);
    case (sel)
      0: begin mem0[wp0] = d; wp0 = wp0 + 4'd1; end
      1: begin mem1[wp1] = d; wp1 = wp1 + 4'd1; end
      default: begin mem2[wp2] = d; wp2 = wp2 + 4'd1; end
    endcase
  endtask

  function automatic logic tx_of(input int sel);
    case (sel)
      0: return tx0;
      1: return tx1;
      default: return tx2;
    endcase
  endfunction

  // Expected line levels per cycle at CLKS_PER_BIT=4: 4 start, 32 data, then idle-high
  function automatic logic [63:0] exp_wave(input logic [7:0] d);
    logic [63:0] w;
    w = '1;
    for (int i = 0; i < 4; i++) w[i] = 1'b0;
    for (int b = 0; b < 8; b++)
      for (int j = 0; j < 4; j++) w[4 + 4*b + j] = d[b];
    return w;
  endfunction

  function automatic logic [7:0] decode(input logic [63:0] w);
    logic [7:0] d;
    for (int b = 0; b < 8; b++) d[b] = w[4 + 4*b + 2];
    return d;
  endfunction

  // Wait for a start bit, then record n per-cycle samples of the line
  task automatic get_frame(input int sel, input int n, output bit ok,
                           output logic [63:0] w, output int t0);
    ok = 1'b0;
    w  = '1;
    t0 = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (tx_of(sel) == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("start_timeout", 64'd0, 64'd1);
      return;
    end
    t0   = cyc;
    w[0] = 1'b0;
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      w[i] = tx_of(sel);
    end
    $display("frame dut=%0d byte=%02h start_cyc=%0d", sel, decode(w), t0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok;
    logic [63:0] w;
    int          t0, tq, prev_t0, r_before;
    bit          any_read, any_txlow, any_busy, any_state;
    bit          found;

    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_tx", tx0, 1);
    chk("rst_read", read0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_state", st0, 0);
    chk("rst_bitcnt", bc0, 0);
    chk("rst_tx_lat1", tx1, 1);
    chk("rst_tx_stop2", tx2, 1);

    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

    // Idle with empty FIFOs for 100 cycles
    any_read = 0; any_txlow = 0; any_busy = 0; any_state = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      any_read  |= read0 | read1 | read2;
      any_txlow |= !tx0 | !tx1 | !tx2;
      any_busy  |= busy0 | busy1 | busy2;
      any_state |= (st0 != 0) | (st1 != 0) | (st2 != 0);
    end
    chk("idle_read", any_read, 0);
    chk("idle_tx", any_txlow, 0);
    chk("idle_busy", any_busy, 0);
    chk("idle_state", any_state, 0);

    // Single byte 0xA5, show-ahead FIFO
    r_before = reads0;
    push(0, 8'hA5);
    tq = cyc;
    get_frame(0, 40, ok, w, t0);
    if (ok) begin
      chk("a5_wave", w, exp_wave(8'hA5));
      chk("a5_byte", decode(w), 8'hA5);
      chk("a5_latency", t0 - tq, 2);
      chk("a5_busy_last", busy0, 1);
      @(negedge clk);
      chk("a5_busy_fall", busy0, 0);
      chk("a5_state_idle", st0, 0);
      chk("a5_reads", reads0 - r_before, 1);
    end

    // Four queued bytes drained back to back
    r_before = reads0;
    prev_t0  = 0;
    for (int f = 0; f < 4; f++) push(0, 8'(f + 1));
    for (int f = 0; f < 4; f++) begin
      get_frame(0, 40, ok, w, t0);
      if (!ok) break;
      chk("burst_byte", decode(w), 64'(f + 1));
      if (f > 0) chk("burst_period", t0 - prev_t0, 42);
      prev_t0 = t0;
    end
    repeat (5) @(negedge clk);
    chk("burst_empty", empty0, 1);
    chk("burst_reads", reads0 - r_before, 4);

    // Registered FIFO, byte 0x3C
    push(1, 8'h3C);
    tq = cyc;
    get_frame(1, 40, ok, w, t0);
    if (ok) begin
      chk("lat1_latency", t0 - tq, 3);
      chk("lat1_byte", decode(w), 8'h3C);
      chk("lat1_wave", w, exp_wave(8'h3C));
      @(negedge clk);
      chk("lat1_waits", waits1, 1);
      chk("lat1_reads", reads1, 1);
    end

    // Reset in DATA at bit index 3, then a clean frame afterwards
    r_before = reads0;
    push(0, 8'h96);
    found = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (st0 == 3'd4 && bc0 == 3'd3) begin
        found = 1;
        break;
      end
    end
    chk("midrst_reach", found, 1);
    rst0 = 1'b1;
    @(negedge clk);
    chk("midrst_tx", tx0, 1);
    chk("midrst_busy", busy0, 0);
    chk("midrst_read", read0, 0);
    chk("midrst_state", st0, 0);
    push(0, 8'h5A);
    @(negedge clk);
    rst0 = 1'b0;
    get_frame(0, 40, ok, w, t0);
    if (ok) begin
      chk("midrst_byte", decode(w), 8'h5A);
      chk("midrst_wave", w, exp_wave(8'h5A));
      @(negedge clk);
      chk("midrst_reads", reads0 - r_before, 2);
      chk("midrst_empty", empty0, 1);
    end

    // Two stop bits, byte 0xFF
    push(2, 8'hFF);
    get_frame(2, 44, ok, w, t0);
    if (ok) begin
      chk("stop2_wave", w, exp_wave(8'hFF));
      chk("stop2_busy_last", busy2, 1);
      @(negedge clk);
      chk("stop2_busy_fall", busy2, 0);
      chk("stop2_stop_cycles", stops2, 8);
      chk("stop2_reads", reads2, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
